// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, RTS, 8N-odd-parity frame, device ACK)
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 6000,
  parameter int TIMEOUT_CYC = 750000
) (
  input  logic       clk50m,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);
  localparam int MAX_CYC = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int CW = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, WAIT_IDLE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          ack_q, ack_d;
  logic          dat_oe_q, dat_oe_d;
  logic          clk_s1_q, clk_s2_q, clk_p_q, dat_s1_q, dat_s2_q;
  logic          fall, timeout, lines_idle, in_frame;

  always_ff @(posedge clk50m) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      ack_q    <= 1'b0;
      dat_oe_q <= 1'b0;
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_p_q  <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      dat_oe_q <= dat_oe_d;
      clk_s1_q <= ps2_clk_i;
      clk_s2_q <= clk_s1_q;
      clk_p_q  <= clk_s2_q;
      dat_s1_q <= ps2_dat_i;
      dat_s2_q <= dat_s1_q;
    end
  end

  assign fall       = clk_p_q & ~clk_s2_q;
  assign lines_idle = clk_s2_q & dat_s2_q;
  assign in_frame   = (state_q == SEND) || (state_q == WAIT_IDLE);
  assign timeout    = in_frame && (cnt_q == CW'(TIMEOUT_CYC - 1));

  // timeout is tested first everywhere so it beats a coincident fall pulse
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (tx_valid) state_d = INHIBIT;
      INHIBIT:   if (cnt_q == CW'(INHIBIT_CYC - 1)) state_d = RTS;
      RTS:       state_d = SEND;
      SEND:      state_d = timeout ? IDLE : (fall && idx_q == 4'd10) ? WAIT_IDLE : SEND;
      WAIT_IDLE: state_d = (timeout || lines_idle) ? IDLE : WAIT_IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = (state_q == IDLE || state_q == RTS) ? '0 : cnt_q + CW'(1);
    idx_d    = (state_q == RTS) ? 4'd0 : (state_q == SEND && fall) ? idx_q + 4'd1 : idx_q;
    data_d   = (state_q == IDLE && tx_valid) ? tx_data : data_q;
    ack_d    = (state_q == SEND && fall && idx_q == 4'd10) ? ~dat_s2_q : ack_q;
    dat_oe_d = dat_oe_q;
    if (state_q == RTS)
      dat_oe_d = 1'b1;
    else if (state_q == SEND && fall)
      dat_oe_d = (idx_q < 4'd8) ? ~data_q[idx_q[2:0]] : (idx_q == 4'd8) ? ^data_q : 1'b0;
  end

  always_comb begin
    tx_ready   = (state_q == IDLE);
    ps2_clk_oe = (state_q == INHIBIT) || (state_q == RTS);
    ps2_dat_oe = (state_q == RTS) || (state_q == SEND && dat_oe_q && !timeout);
    tx_done    = timeout || (state_q == WAIT_IDLE && lines_idle);
    tx_err     = timeout || (state_q == WAIT_IDLE && lines_idle && !ack_q);
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 host transmitter bench with a behavioural open-drain device model
module tb_ps2_host_tx;
  localparam int INH = 40;
  localparam int TO  = 2000;
  localparam int H   = 12;

  logic       clk50m = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_done, tx_err, ps2_clk_oe, ps2_dat_oe, ps2_clk_i, ps2_dat_i;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         exp_err;
  } vec_t;
  vec_t vecs[6];

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
    .clk50m(clk50m), .reset_n(reset_n), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err),
    .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clk50m = ~clk50m;

  // wired-AND open-drain bus with pull-ups
  assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

  // line levels the device should see: data LSB first, odd parity, stop high
  function automatic logic [9:0] frame_of(input logic [7:0] d);
    logic [9:0] f;
    f[7:0] = d;
    f[8]   = ($countones(d) % 2 == 0);
    f[9]   = 1'b1;
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic wait_rts(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk50m);
      if (ps2_clk_oe && ps2_dat_oe) ok = 1'b1;
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
        @(negedge clk50m);
        if (!ps2_clk_oe) ok = 1'b1;
      end
    end
  endtask

  task automatic dev_clocks(input int n, input bit ack, output logic [9:0] bits);
    bits = '0;
    for (int k = 0; k < n; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk50m);
      dev_clk_low = 1'b0;
      if (k < 10) bits[k] = ps2_dat_i;
      if (k == 9) dev_dat_low = ack;
      repeat (H) @(negedge clk50m);
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic run_device(input bit ack, output logic [9:0] bits, output bit ok);
    bits = '0;
    wait_rts(ok);
    if (ok) begin
      repeat (H) @(negedge clk50m);
      dev_clocks(11, ack, bits);
    end
  endtask

  task automatic wait_done(output bit got, output logic err);
    got = 1'b0;
    err = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk50m);
      if (tx_done) begin
        got = 1'b1;
        err = tx_err;
      end
    end
  endtask

  task automatic intrude();
    repeat (100) @(negedge clk50m);
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk50m);
      chk("busy_ready", tx_ready, 0);
    end
    tx_valid = 1'b0;
  endtask

  // entered and left on a negedge where tx_ready is expected high
  task automatic send(input logic [7:0] d, input bit ack, input bit exp_err, input bit intr);
    logic [9:0] bits;
    bit         ok, got;
    logic       err;
    chk("ready_before", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk50m);
    tx_valid = 1'b0;
    chk("inhibit_start", {ps2_clk_oe, ps2_dat_oe, tx_ready}, 3'b100);
    fork
      run_device(ack, bits, ok);
      wait_done(got, err);
      if (intr) intrude();
    join
    chk("rts_seen", ok, 1);
    chk("frame_bits", bits, frame_of(d));
    chk("done_seen", got, 1);
    chk("err", err, exp_err);
    @(negedge clk50m);
    chk("pulse_end", {tx_done, tx_err, tx_ready}, 3'b001);
  endtask

  initial begin
    logic [9:0] bits;
    bit         ok, started;
    int         n;
    logic [7:0] d;
    bit         a;
    vecs[0] = '{8'hED, 1'b1, 1'b0};
    vecs[1] = '{8'h02, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 1'b1, 1'b0};
    vecs[4] = '{8'h01, 1'b0, 1'b1};
    vecs[5] = '{8'h7E, 1'b1, 1'b0};

    repeat (3) @(negedge clk50m);
    chk("reset_state", {tx_ready, tx_done, tx_err, ps2_clk_oe, ps2_dat_oe}, 5'b10000);
    reset_n = 1'b1;
    @(negedge clk50m);

    // vectors 0 and 1 run back-to-back: ED then 02
    for (int i = 0; i < 6; i++) send(vecs[i].data, vecs[i].ack, vecs[i].exp_err, 1'b0);

    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      a = ($urandom_range(0, 3) != 0);
      send(d, a, !a, 1'b0);
    end

    send(8'hA3, 1'b1, 1'b0, 1'b1);
    started = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk50m);
      if (ps2_clk_oe || !tx_ready) started = 1'b1;
    end
    chk("no_replay", started, 0);

    // device never clocks: inhibit length, RTS, then timeout
    chk("to_ready", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(negedge clk50m);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n < 5000) begin
      n++;
      @(negedge clk50m);
    end
    chk("inhibit_len", n, INH);
    chk("rts_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b11);
    @(negedge clk50m);
    chk("start_bit", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
    n = 1;
    while (!tx_done && n < 5000) begin
      @(negedge clk50m);
      n++;
    end
    chk("timeout_len", n, TO);
    chk("timeout_out", {tx_done, tx_err, ps2_clk_oe, ps2_dat_oe}, 4'b1100);
    @(negedge clk50m);
    chk("timeout_end", {tx_done, tx_err, tx_ready}, 3'b001);

    // reset after the 4th data bit
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    @(negedge clk50m);
    tx_valid = 1'b0;
    wait_rts(ok);
    chk("rst_rts", ok, 1);
    repeat (H) @(negedge clk50m);
    dev_clocks(4, 1'b0, bits);
    chk("rst_bits", bits[3:0], 4'h5);
    chk("rst_pre_dat", ps2_dat_oe, 1);
    reset_n = 1'b0;
    @(negedge clk50m);
    chk("rst_abort", {ps2_clk_oe, ps2_dat_oe, tx_ready, tx_done, tx_err}, 5'b00100);
    repeat (2) @(negedge clk50m);
    reset_n = 1'b1;
    @(negedge clk50m);
    send(8'hED, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
